iomem_arbiter: RTL and testbench
================================

# iomem_arbiter

Two-master arbiter that shares the core's single `iomem` port between the instruction-cache refill engine (master 0) and the data-side load/store unit (master 1). It sits between those requesters and the top-level `iomem_*` pins. It runs round-robin arbitration with one outstanding transaction, registers all outbound fields, and enforces a bus timeout that returns an error instead of hanging the core.

## Interface
- `TIMEOUT_W`, default 8: width of the timeout counter.
- `TIMEOUT`, default 255: cycles of `iomem_valid_o` without `iomem_ready_i` before abort. 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_valid_i`  in  1  master 0 request. Held with fields stable until `m0_ready_o`.
- `m0_addr_i`  in  32  master 0 address.
- `m0_wdata_i`  in  32  master 0 write data.
- `m0_wstrb_i`  in  4  master 0 byte strobes; 0 = read.
- `m0_ready_o`  out  1  one-cycle completion pulse.
- `m0_rdata_o`  out  32  read data, valid with `m0_ready_o`, held until the next m0 completion.
- `m0_err_o`  out  1  timeout flag, pulses with `m0_ready_o`.
- `m1_*`  same seven ports as m0, for master 1.
- `iomem_valid_o`  out  1  bus request.
- `iomem_addr_o`  out  32  registered address.
- `iomem_wdata_o`  out  32  registered write data.
- `iomem_wstrb_o`  out  4  registered strobes.
- `iomem_ready_i`  in  1  bus completion.
- `iomem_rdata_i`  in  32  bus read data, sampled with `iomem_ready_i`.
- `grant_o`  out  1  index of the current or last granted master.

## Operation
- **States:** IDLE, BUSY, RESP.
- **IDLE:**
  - If no valid is high, stay in IDLE.
  - If only one valid is high, grant that master.
  - If both are high, grant the master other than `last_grant`.
  - On grant: latch the master's addr/wdata/wstrb into the `iomem_*` registers, set `grant_o` and `last_grant`, clear the timeout counter, go to BUSY.
- **BUSY:**
  - `iomem_valid_o`=1; outbound fields frozen.
  - On `iomem_ready_i`=1: capture `iomem_rdata_i` into the granted master's rdata register, set err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT` (and `TIMEOUT`≠0): set the granted master's rdata to 0, set err=1, go to RESP.
  - If `iomem_ready_i` and the timeout occur in the same cycle, ready wins and err=0.
- **RESP:**
  - `iomem_valid_o`=0.
  - Granted master's `ready_o`=1 and `err_o` as captured; the other master's ready/err are 0.
  - Master valids are ignored in this cycle. The completing master must drop or change its request after seeing ready.
  - Always go to IDLE.
- **Don't-cares:**
  - `iomem_ready_i` is ignored outside BUSY.
  - The arbiter does not inspect wstrb; reads and writes are handled identically.
  - A write's captured rdata is whatever the bus returns.
- **Counter:** `TIMEOUT_W` bits, saturating. `TIMEOUT` must be less than 2^`TIMEOUT_W`.

## Timing
- **Reset values:**
  - state=IDLE, `last_grant`=1, so m0 wins the first tie.
  - All `*_ready_o`, `*_err_o`, `iomem_valid_o`=0.
  - All rdata, `iomem_addr_o`/`wdata_o`/`wstrb_o`=0; `grant_o`=0.
- **Reset mid-transaction:** `iomem_valid_o` drops the cycle after `rst` is sampled high. No ready pulse is issued for the aborted transaction.
- **Latency:**
  - Request sampled in IDLE at edge E0 → `iomem_valid_o` high after E0.
  - `iomem_ready_i` sampled at edge Ek → master ready high for exactly one cycle after Ek.
  - Minimum request-to-ready: 2 cycles.
  - Minimum issue spacing: 3 cycles (IDLE→BUSY→RESP→IDLE).
- **Timeout:** with `TIMEOUT`=N, the error pulse appears N+1 cycles after `iomem_valid_o` rises if no ready is seen.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Single read:** m0 requests addr 0x0000_1000, wstrb 0; bus answers ready after 3 cycles with 0xDEAD_BEEF → `iomem_addr_o`=0x1000; `m0_ready_o` is a 1-cycle pulse with rdata 0xDEAD_BEEF and err 0; `m1_ready_o` stays 0.
- **Tie alternation:** both masters hold valid for 4 transactions, bus ready immediately → grant order 0,1,0,1. Each master's rdata matches its own bus responses.
- **Write pass-through:** m1 sends addr 0x2000_0004, wdata 0x1234_5678, wstrb 0xC → identical values on `iomem_*` for the whole BUSY period; `m1_ready_o` pulses after ready.
- **Timeout:** `TIMEOUT`=4, bus never ready → `iomem_valid_o` high for 5 cycles then 0; `m0_ready_o`=1 with `m0_err_o`=1 and rdata 0. A following transaction completes normally.
- **Ready on timeout cycle:** `TIMEOUT`=4, ready asserted on the 5th BUSY cycle with 0xA5A5_A5A5 → err 0, rdata 0xA5A5_A5A5.
- **Reset in BUSY:** assert `rst` for 1 cycle while BUSY → next cycle all outputs at reset values, no ready pulse. A subsequent tie grants m0.

Source files
------------

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one iomem port between the I-cache refill (m0) and LSU (m1).
// One transaction in flight, fully registered outputs, bus timeout returns an error response.
module iomem_arbiter #(
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_wstrb_i,
   output logic        m0_ready_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   input  logic        m1_valid_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_wstrb_i,
   output logic        m1_ready_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic        iomem_valid_o,
   output logic [31:0] iomem_addr_o,
   output logic [31:0] iomem_wdata_o,
   output logic [3:0]  iomem_wstrb_o,
   input  logic        iomem_ready_i,
   input  logic [31:0] iomem_rdata_i,
   output logic        grant_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t               state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 last_grant_q, last_grant_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           wstrb_q, wstrb_d;
   logic                 m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
   logic                 m0_err_q, m0_err_d, m1_err_q, m1_err_d;
   logic [31:0]          m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

   logic                 sel;
   logic                 done;
   logic                 err;
   logic [31:0]          rd;
   logic                 timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_W'(TIMEOUT));

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      m0_ready_d   = 1'b0;
      m1_ready_d   = 1'b0;
      m0_err_d     = 1'b0;
      m1_err_d     = 1'b0;
      sel          = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      rd           = '0;

      case (state_q)
         IDLE: begin
            if (m0_valid_i || m1_valid_i) begin
               // On a tie the master that did not win last time goes next.
               sel          = (m0_valid_i && m1_valid_i) ? ~last_grant_q : m1_valid_i;
               grant_d      = sel;
               last_grant_d = sel;
               addr_d       = sel ? m1_addr_i  : m0_addr_i;
               wdata_d      = sel ? m1_wdata_i : m0_wdata_i;
               wstrb_d      = sel ? m1_wstrb_i : m0_wstrb_i;
               cnt_d        = '0;
               valid_d      = 1'b1;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (iomem_ready_i) begin
               done = 1'b1;
               rd   = iomem_rdata_i;
            end else if (timeout_hit) begin
               done = 1'b1;
               err  = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
            if (done) begin
               valid_d = 1'b0;
               state_d = RESP;
               if (grant_q) begin
                  m1_ready_d = 1'b1;
                  m1_err_d   = err;
                  m1_rdata_d = rd;
               end else begin
                  m0_ready_d = 1'b1;
                  m0_err_d   = err;
                  m0_rdata_d = rd;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         valid_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         m0_ready_q   <= m0_ready_d;
         m1_ready_q   <= m1_ready_d;
         m0_err_q     <= m0_err_d;
         m1_err_q     <= m1_err_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign m0_ready_o    = m0_ready_q;
   assign m0_rdata_o    = m0_rdata_q;
   assign m0_err_o      = m0_err_q;
   assign m1_ready_o    = m1_ready_q;
   assign m1_rdata_o    = m1_rdata_q;
   assign m1_err_o      = m1_err_q;
   assign iomem_valid_o = valid_q;
   assign iomem_addr_o  = addr_q;
   assign iomem_wdata_o = wdata_q;
   assign iomem_wstrb_o = wstrb_q;
   assign grant_o       = grant_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter with TIMEOUT=4; expected values are hand-derived per scenario.
module tb_iomem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid_i, m1_valid_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m0_wstrb_i, m1_wstrb_i;
   logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        iomem_valid_o, iomem_ready_i, grant_o;
   logic [31:0] iomem_addr_o, iomem_wdata_o, iomem_rdata_i;
   logic [3:0]  iomem_wstrb_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rd [2];

   always #5 clk = ~clk;

   iomem_arbiter #(.TIMEOUT_W(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
      .m0_err_o(m0_err_o),
      .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
      .m1_err_o(m1_err_o),
      .iomem_valid_o(iomem_valid_o), .iomem_addr_o(iomem_addr_o),
      .iomem_wdata_o(iomem_wdata_o), .iomem_wstrb_o(iomem_wstrb_o),
      .iomem_ready_i(iomem_ready_i), .iomem_rdata_i(iomem_rdata_i),
      .grant_o(grant_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_valid_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
      m1_valid_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
      iomem_ready_i = 1'b0; iomem_rdata_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"},  32'(iomem_valid_o), 32'd0);
      check({tag, "_m0rdy"},  32'(m0_ready_o),    32'd0);
      check({tag, "_m1rdy"},  32'(m1_ready_o),    32'd0);
      check({tag, "_m0err"},  32'(m0_err_o),      32'd0);
      check({tag, "_m1err"},  32'(m1_err_o),      32'd0);
      check({tag, "_grant"},  32'(grant_o),       32'd0);
      check({tag, "_addr"},   iomem_addr_o,       32'd0);
      check({tag, "_wdata"},  iomem_wdata_o,      32'd0);
      check({tag, "_wstrb"},  32'(iomem_wstrb_o), 32'd0);
      check({tag, "_m0rd"},   m0_rdata_o,         32'd0);
      check({tag, "_m1rd"},   m1_rdata_o,         32'd0);
   endtask

   initial begin
      idle_inputs();
      do_reset();
      check_reset_state("rst");

      // Single read from m0, ready on the 3rd BUSY edge.
      m0_valid_i = 1'b1; m0_addr_i = 32'h0000_1000; m0_wstrb_i = 4'h0;
      tick();
      check("rd_valid",  32'(iomem_valid_o), 32'd1);
      check("rd_addr",   iomem_addr_o,       32'h0000_1000);
      check("rd_grant",  32'(grant_o),       32'd0);
      tick();
      check("rd_busy_rdy", 32'(m0_ready_o),  32'd0);
      tick();
      iomem_ready_i = 1'b1; iomem_rdata_i = 32'hDEAD_BEEF;
      tick();
      check("rd_m0rdy",  32'(m0_ready_o),    32'd1);
      check("rd_m0rd",   m0_rdata_o,         32'hDEAD_BEEF);
      check("rd_m0err",  32'(m0_err_o),      32'd0);
      check("rd_m1rdy",  32'(m1_ready_o),    32'd0);
      check("rd_vdrop",  32'(iomem_valid_o), 32'd0);
      m0_valid_i = 1'b0; iomem_ready_i = 1'b0;
      tick();
      check("rd_pulse",  32'(m0_ready_o),    32'd0);
      check("rd_hold",   m0_rdata_o,         32'hDEAD_BEEF);

      // Tie alternation from reset: grants 0,1,0,1 with an always-ready bus.
      do_reset();
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      m0_valid_i = 1'b1; m0_addr_i = 32'h0000_0100;
      m1_valid_i = 1'b1; m1_addr_i = 32'h0000_0200;
      iomem_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("tie_grant", 32'(grant_o), 32'(i % 2));
         check("tie_addr",  iomem_addr_o, (i % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
         iomem_rdata_i = 32'h1000_0000 + 32'(i);
         exp_rd[i % 2] = iomem_rdata_i;
         tick();
         check("tie_m0rdy", 32'(m0_ready_o), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("tie_m1rdy", 32'(m1_ready_o), (i % 2 == 1) ? 32'd1 : 32'd0);
         check("tie_m0rd",  m0_rdata_o, exp_rd[0]);
         check("tie_m1rd",  m1_rdata_o, exp_rd[1]);
         tick();
      end
      idle_inputs();
      tick();

      // Write pass-through from m1; a stray m0 request during BUSY must not disturb the fields.
      m1_valid_i = 1'b1; m1_addr_i = 32'h2000_0004; m1_wdata_i = 32'h1234_5678; m1_wstrb_i = 4'hC;
      tick();
      m0_valid_i = 1'b1; m0_addr_i = 32'hFFFF_FFF0; m0_wdata_i = 32'h0BAD_0BAD; m0_wstrb_i = 4'hF;
      for (int k = 0; k < 2; k++) begin
         check("wr_valid", 32'(iomem_valid_o), 32'd1);
         check("wr_grant", 32'(grant_o),       32'd1);
         check("wr_addr",  iomem_addr_o,       32'h2000_0004);
         check("wr_wdata", iomem_wdata_o,      32'h1234_5678);
         check("wr_wstrb", 32'(iomem_wstrb_o), 32'hC);
         tick();
      end
      m0_valid_i = 1'b0;
      iomem_ready_i = 1'b1; iomem_rdata_i = 32'hCAFE_0000;
      tick();
      check("wr_m1rdy", 32'(m1_ready_o), 32'd1);
      check("wr_m1rd",  m1_rdata_o,      32'hCAFE_0000);
      check("wr_m0rdy", 32'(m0_ready_o), 32'd0);
      idle_inputs();
      tick();

      // Timeout: valid high for 5 cycles, then an error response with zero data.
      m0_valid_i = 1'b1; m0_addr_i = 32'h0000_3000;
      tick();
      check("to_valid0", 32'(iomem_valid_o), 32'd1);
      for (int k = 1; k < 5; k++) begin
         tick();
         check("to_validk", 32'(iomem_valid_o), 32'd1);
         check("to_nordy",  32'(m0_ready_o),    32'd0);
      end
      tick();
      check("to_vdrop", 32'(iomem_valid_o), 32'd0);
      check("to_m0rdy", 32'(m0_ready_o),    32'd1);
      check("to_m0err", 32'(m0_err_o),      32'd1);
      check("to_m0rd",  m0_rdata_o,         32'd0);
      m0_valid_i = 1'b0;
      tick();
      check("to_errpulse", 32'(m0_err_o), 32'd0);
      m0_valid_i = 1'b1; m0_addr_i = 32'h0000_3004;
      tick();
      iomem_ready_i = 1'b1; iomem_rdata_i = 32'h55AA_55AA;
      tick();
      check("to_next_rdy", 32'(m0_ready_o), 32'd1);
      check("to_next_err", 32'(m0_err_o),   32'd0);
      check("to_next_rd",  m0_rdata_o,      32'h55AA_55AA);
      idle_inputs();
      tick();

      // Ready arrives on the same edge the timeout would fire: ready wins.
      m1_valid_i = 1'b1; m1_addr_i = 32'h0000_4000;
      tick();
      for (int k = 1; k < 5; k++) tick();
      check("rt_valid", 32'(iomem_valid_o), 32'd1);
      iomem_ready_i = 1'b1; iomem_rdata_i = 32'hA5A5_A5A5;
      tick();
      check("rt_m1rdy", 32'(m1_ready_o), 32'd1);
      check("rt_m1err", 32'(m1_err_o),   32'd0);
      check("rt_m1rd",  m1_rdata_o,      32'hA5A5_A5A5);
      idle_inputs();
      tick();

      // Reset while BUSY: everything back to reset values, no completion pulse.
      m0_valid_i = 1'b1; m0_addr_i = 32'h0000_5000; m0_wdata_i = 32'h7777_7777; m0_wstrb_i = 4'h3;
      tick();
      check("rb_valid", 32'(iomem_valid_o), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("rb");
      m0_valid_i = 1'b0;
      iomem_ready_i = 1'b1; iomem_rdata_i = 32'h9999_9999;
      tick();
      check("rb_nordy0", 32'(m0_ready_o), 32'd0);
      tick();
      check("rb_nordy1", 32'(m0_ready_o), 32'd0);
      check("rb_novalid", 32'(iomem_valid_o), 32'd0);
      iomem_ready_i = 1'b0;
      m0_valid_i = 1'b1; m0_addr_i = 32'h0000_6000;
      m1_valid_i = 1'b1; m1_addr_i = 32'h0000_7000;
      tick();
      check("rb_tie_grant", 32'(grant_o),   32'd0);
      check("rb_tie_addr",  iomem_addr_o,   32'h0000_6000);
      iomem_ready_i = 1'b1; iomem_rdata_i = 32'h0102_0304;
      tick();
      check("rb_tie_m0rdy", 32'(m0_ready_o), 32'd1);
      check("rb_tie_m0rd",  m0_rdata_o,      32'h0102_0304);
      check("rb_tie_m1rdy", 32'(m1_ready_o), 32'd0);
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
